// File: rtl/mod47_pkg.sv
// Shared constants and state encoding for the mod-47 residue accumulator family.
package mod47_pkg;

  localparam int MOD   = 47;
  localparam int RES_W = 6;
  localparam int CNT_W = 7;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/mod47_add.sv
// Combinational modular adder: s = (a + b) mod 47.
// The full-scale sum of two 6-bit operands stays below 3*47, so at most two
// conditional subtractions are ever needed and the result is always 0..46.
module mod47_add
  import mod47_pkg::*;
(
  input  logic [RES_W-1:0] a,
  input  logic [RES_W-1:0] b,
  output logic [RES_W-1:0] s
);

  localparam logic [RES_W:0] MOD_1X = (RES_W+1)'(MOD);
  localparam logic [RES_W:0] MOD_2X = (RES_W+1)'(2 * MOD);

  logic [RES_W:0] sum;
  logic [RES_W:0] red;

  assign sum = {1'b0, a} + {1'b0, b};

  // Reduce the raw sum by zero, one or two multiples of the modulus.
  always_comb begin
    red = sum;
    if (sum >= MOD_2X) begin
      red = sum - MOD_2X;
    end else if (sum >= MOD_1X) begin
      red = sum - MOD_1X;
    end
  end

  assign s = red[RES_W-1:0];

endmodule

// File: rtl/mod47_accum.sv
// Frame accumulator: sums per-nibble residues mod 47 over a frame delimited by
// in_last, then presents the residue and beat count until downstream takes it.
// Input acceptance and output valid both derive from the registered state, so
// there is no combinational path from the input side to the output side.
module mod47_accum
  import mod47_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RES_W-1:0] in_res,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_res,
  output logic [CNT_W-1:0] out_terms,
  output logic             err
);

  state_e           state;
  logic [RES_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [RES_W-1:0] sum;
  logic             accept;

  // Beat counter increments stick at the top value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? CNT_MAX : c + 1'b1;
  endfunction

  assign in_ready  = (state == ST_ACC);
  assign out_valid = (state == ST_HOLD);
  assign accept    = in_valid && in_ready;

  mod47_add u_add (
    .a (acc),
    .b (in_res),
    .s (sum)
  );

  // Frame FSM: accumulate in ACC, hold the registered result in HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ACC;
      acc       <= '0;
      cnt       <= '0;
      out_res   <= '0;
      out_terms <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (accept) begin
            // Out-of-range residues are flagged but still reduced normally.
            if (in_res >= RES_W'(MOD)) begin
              err <= 1'b1;
            end
            if (in_last) begin
              out_res   <= sum;
              out_terms <= sat_inc(cnt);
              acc       <= '0;
              cnt       <= '0;
              state     <= ST_HOLD;
            end else begin
              acc <= sum;
              cnt <= sat_inc(cnt);
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state <= ST_ACC;
          end
        end
        default: begin
          state <= ST_ACC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod47_accum.sv
// Directed bench for mod47_accum: each task drives one scenario and checks
// outputs against hand-computed values. Inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_mod47_accum;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_res;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_res;
  logic [6:0] out_terms;
  logic       err;

  int checks;
  int fails;

  mod47_accum dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_res    (in_res),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_terms (out_terms),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for exactly one edge, after waiting (bounded) for in_ready.
  task automatic send_beat(input logic [5:0] r, input logic l);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL beat_wait: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_res   = r;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_res   = 6'd0;
  endtask

  // Check the presented result, then hand it off and check valid drops.
  task automatic check_result(input string name, input logic [5:0] exp_res,
                              input logic [6:0] exp_terms);
    checks++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s_valid: out_valid=%b required 1", name, out_valid);
    end
    checks++;
    if (out_res !== exp_res) begin
      fails++;
      $display("FAIL %s_res: out_res=%0d required %0d", name, out_res, exp_res);
    end
    checks++;
    if (out_terms !== exp_terms) begin
      fails++;
      $display("FAIL %s_terms: out_terms=%0d required %0d", name, out_terms, exp_terms);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s_handoff: out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({out_valid, in_ready, out_res, out_terms, err} !== {1'b0, 1'b1, 6'd0, 7'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset: valid=%b ready=%b res=%0d terms=%0d err=%b required 0 1 0 0 0",
               out_valid, in_ready, out_res, out_terms, err);
    end
  endtask

  // 46+46+46 = 138 = 2*47 + 44, with idle gaps between beats.
  task automatic test_three_46();
    out_ready = 1'b1;
    send_beat(6'd46, 1'b0);
    tick();
    tick();
    send_beat(6'd46, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL idle_no_output: out_valid=%b required 0", out_valid);
    end
    send_beat(6'd46, 1'b1);
    check_result("three_46", 6'd44, 7'd3);
    checks++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL three_46_err: err=%b required 0", err);
    end
  endtask

  task automatic test_single();
    send_beat(6'd5, 1'b1);
    check_result("single", 6'd5, 7'd1);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_beat(6'd10, 1'b1);
    in_valid = 1'b1;
    in_res   = 6'd7;
    in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_res !== 6'd10 || out_terms !== 7'd1 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL hold_cycle%0d: valid=%b res=%0d terms=%0d ready=%b required 1 10 1 0",
                 i, out_valid, out_res, out_terms, in_ready);
      end
      if (i < 2) tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_res   = 6'd0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL hold_handoff: valid=%b ready=%b required 0 1", out_valid, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL hold_no_accept: out_valid=%b required 0", out_valid);
    end
  endtask

  // 63 -> 16, then 16+46 = 62 -> 15; err is sticky across a clean frame.
  task automatic test_err();
    send_beat(6'd63, 1'b0);
    send_beat(6'd46, 1'b1);
    checks++;
    if (err !== 1'b1) begin
      fails++;
      $display("FAIL err_set: err=%b required 1", err);
    end
    check_result("err_frame", 6'd15, 7'd2);
    send_beat(6'd3, 1'b1);
    check_result("clean_after_err", 6'd3, 7'd1);
    checks++;
    if (err !== 1'b1) begin
      fails++;
      $display("FAIL err_sticky: err=%b required 1", err);
    end
  endtask

  task automatic test_abort();
    send_beat(6'd20, 1'b0);
    send_beat(6'd30, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL abort_reset: valid=%b err=%b ready=%b required 0 0 1", out_valid, err, in_ready);
    end
    send_beat(6'd10, 1'b1);
    check_result("after_abort", 6'd10, 7'd1);
  endtask

  // 100 mod 47 = 6; 130 mod 47 = 36 with the count saturated.
  task automatic test_long();
    for (int i = 1; i <= 100; i++) send_beat(6'd1, (i == 100));
    check_result("long100", 6'd6, 7'd100);
    for (int i = 1; i <= 130; i++) send_beat(6'd1, (i == 130));
    check_result("long130", 6'd36, 7'd127);
  endtask

  initial begin
    checks    = 0;
    fails     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_res    = 6'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_three_46();
    test_single();
    test_backpressure();
    test_err();
    test_abort();
    test_long();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mod47_accum.md
MOD47_ACCUM -- requirements
Module: mod47_accum

Interface
REQ-001 SHALL have ports in this order: clk  input  1  rising-edge clock (sole clock); rst  input  1  synchronous reset, active-high.
REQ-002 SHALL have in_valid  input  1  upstream residue beat valid.
REQ-003 SHALL have in_ready  output  1  block can accept a beat.
REQ-004 SHALL have in_res  input  6  nibble-residue from the upstream per-nibble mod-47 LUT stage, nominally 0..46.
REQ-005 SHALL have in_last  input  1  final beat of the current frame.
REQ-006 SHALL have out_valid  output  1  frame result valid.
REQ-007 SHALL have out_ready  input  1  downstream accepts the result.
REQ-008 SHALL have out_res  output  6  frame sum mod 47, range 0..46.
REQ-009 SHALL have out_terms  output  7  beats in the frame, saturating at 127.
REQ-010 SHALL have err  output  1  sticky flag: some in_res >= 47 was accepted.

Function
REQ-011 A beat SHALL be accepted only on a cycle where in_valid and in_ready are both 1.
REQ-012 in_ready SHALL equal NOT out_valid (state ACC), so no input is accepted while a result is pending.
REQ-013 States SHALL be ACC and HOLD; ACC->HOLD on an accepted beat with in_last=1; HOLD->ACC when out_valid and out_ready are both 1.
REQ-014 On each accepted non-last beat: acc <= (acc + in_res) mod 47 and cnt <= sat127(cnt + 1).
REQ-015 On an accepted last beat: out_res <= (acc + in_res) mod 47, out_terms <= sat127(cnt + 1), out_valid <= 1 on the next edge (latency 1 cycle); acc and cnt SHALL clear to 0 on the same edge.
REQ-016 Modular add SHALL take acc (0..46) plus in_res (0..63), giving a sum of 0..109; subtract 47 once if sum >= 47 and twice if sum >= 94; the result is always 0..46.
REQ-017 An accepted in_res >= 47 SHALL set err = 1 on the next edge; the value SHALL still be reduced per REQ-016.
REQ-018 out_res and out_terms SHALL be held stable while out_valid = 1 and out_ready = 0.
REQ-019 On result handoff, out_valid SHALL drop on the next edge; in_ready rises in the same cycle, so the next beat is accepted no earlier than the cycle after handoff.
REQ-020 in_last on the first beat SHALL produce a one-term frame: out_res = in_res mod 47, out_terms = 1.
REQ-021 in_valid = 0 SHALL leave acc and cnt unchanged; there is no timeout.
REQ-022 With cnt = 127, further beats SHALL keep out_terms at 127; the residue SHALL remain exact.

Reset
REQ-023 With rst = 1 at a clock edge, the next state SHALL be: state ACC, acc = 0, cnt = 0, out_valid = 0, out_res = 0, out_terms = 0, err = 0; in_ready = 1 after that edge.
REQ-024 Reset SHALL take priority over all handshakes; a frame interrupted mid-way is discarded with no output.
REQ-025 err SHALL be cleared only by rst.

Structure
REQ-026 Package mod47_pkg SHALL hold MOD = 47, RES_W = 6, CNT_W = 7, and the ACC/HOLD state enum.
REQ-027 The combinational reduction in REQ-016 SHALL be a sub-module, mod47_add (inputs a[5:0] and b[5:0], output s[5:0]), reused by the later tree-adder variant.
REQ-028 The block SHALL have no combinational path from in_* to out_*; in_ready SHALL depend on registered state only.

Verification
REQ-029 Frame 46, 46, 46(last), out_ready = 1 -> out_res = 44, out_terms = 3, err = 0, one cycle after the last beat.
REQ-030 Single beat 5(last) -> out_res = 5, out_terms = 1.
REQ-031 Frame 10(last), out_ready = 0 for 3 cycles -> out_valid held, out_res = 10 stable, in_ready = 0; handoff on the 4th cycle; in_ready = 1 on the following cycle.
REQ-032 Frame 63, 46(last) -> out_res = 15, err = 1; err stays 1 after the next clean frame.
REQ-033 Beats 20, 30, then rst pulse, then frame 10(last) -> out_res = 10, out_terms = 1, no output for the aborted frame.
REQ-034 100 beats of value 1, last on the 100th -> out_res = 6, out_terms = 100; 130 beats of value 1 -> out_res = 36, out_terms = 127.
